input_cmd_scheduler: RTL and testbench

Sits between the input sources (keyboard decoder levels and the three push-buttons) and `player_control`. Converts held direction levels into discrete move commands with debounce and auto-repeat. Resolves left/right conflicts and arbitrates the three command sources round-robin onto a single valid/ready command channel. The channel is gated off while the game reports finished.

---
 rtl/input_cmd_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_input_cmd_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_cmd_scheduler.sv
// input_cmd_scheduler
//   Turns keyboard levels and raw push-buttons into discrete move commands.
//   Buttons are synchronised and debounced. Held directions auto-repeat.
//   Simultaneous left+right is suppressed. The three directions are
//   arbitrated round-robin onto one valid/ready command channel, which is
//   gated while the game reports finished.
//
// Ports
//   clk                            : single clock, rising edge
//   rst                            : asynchronous reset, active low
//   key_left/key_right/key_fall    : keyboard levels, synchronous to clk
//   btn_left/btn_right/btn_fall    : raw asynchronous push-buttons
//   finish                         : game over, suppresses new commands
//   cmd_ready                      : consumer accepts the presented command
//   cmd_valid                      : command presented
//   cmd_code[1:0]                  : 01 left, 10 right, 11 fall, 00 none
//   held[2:0]                      : {fall, right, left} levels after conflict rule
module input_cmd_scheduler #(
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_fall,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fall,
  input  logic       finish,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [2:0] held
);

  localparam int unsigned DW = $clog2(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES);
  localparam logic [15:0]   RPT_DLY    = 16'(REPEAT_DELAY);
  localparam logic [15:0]   RPT_RELOAD = 16'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // Round-robin positions: 0 = fall, 1 = left, 2 = right.
  // Vector bit indices: 0 = left, 1 = right, 2 = fall.
  function automatic logic [1:0] pos_bit(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd2;
      2'd1:    return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] pos_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [2:0]         btn_raw;
  logic [2:0]         key_lvl;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]         deb_q, deb_d;
  logic [2:0]         lvl_raw, lvl_eff;
  logic [2:0]         lvl_q;
  logic [2:0]         rise;
  logic [2:0][15:0]   rep_q, rep_d;
  logic [2:0]         set_req;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         grant_vec;
  state_t             state_q, state_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0]         gpos_q, gpos_d;
  logic [1:0]         code_q, code_d;
  logic [1:0]         srch_pos;
  logic               found;

  assign btn_raw = {btn_fall, btn_right, btn_left};
  assign key_lvl = {key_fall, key_right, key_left};

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the counter runs only while the synced value disagrees with
  // the debounced state; DEB_CYCLES consecutive disagreements flip it.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] + DW'(1) == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Combined level with left/right conflict suppression.
  always_comb begin
    lvl_raw = key_lvl | deb_q;
    lvl_eff = lvl_raw;
    if (lvl_raw[0] && lvl_raw[1]) begin
      lvl_eff[1:0] = 2'b00;
    end
  end

  assign rise = lvl_eff & ~lvl_q;

  // Request generation. The repeat counter counts held cycles since the
  // press; on reaching REPEAT_DELAY it reloads so that it hits the same
  // value again every REPEAT_RATE cycles.
  always_comb begin
    rep_d   = '0;
    set_req = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!finish && lvl_eff[i]) begin
        if (rise[i]) begin
          set_req[i] = 1'b1;
        end else if (rep_q[i] + 16'd1 == RPT_DLY) begin
          set_req[i] = 1'b1;
          rep_d[i]   = RPT_RELOAD;
        end else begin
          rep_d[i] = rep_q[i] + 16'd1;
        end
      end
    end
  end

  // Arbiter next-state and grant.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gpos_d    = gpos_q;
    code_d    = code_q;
    grant_vec = '0;
    srch_pos  = rr_q;
    found     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!finish && (|pend_q)) begin
          for (int unsigned k = 0; k < 3; k++) begin
            if (!found && pend_q[pos_bit(srch_pos)]) begin
              found                       = 1'b1;
              grant_vec[pos_bit(srch_pos)] = 1'b1;
              gpos_d                      = srch_pos;
              code_d                      = pos_bit(srch_pos) + 2'd1;
            end
            srch_pos = pos_next(srch_pos);
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_IDLE;
          rr_d    = pos_next(gpos_q);
          code_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A set in the same cycle as a grant wins, leaving the flag pending.
  always_comb begin
    pend_d = (pend_q & ~grant_vec) | set_req;
    if (finish) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_q <= '0;
      deb_q     <= '0;
      lvl_q     <= '0;
      rep_q     <= '0;
      pend_q    <= '0;
      state_q   <= S_IDLE;
      rr_q      <= '0;
      gpos_q    <= '0;
      code_q    <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
      lvl_q     <= lvl_eff;
      rep_q     <= rep_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      rr_q      <= rr_d;
      gpos_q    <= gpos_d;
      code_q    <= code_d;
    end
  end

  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_code  = code_q;
  assign held      = lvl_q;

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Testbench for input_cmd_scheduler: directed scenarios followed by a random
// phase, all checked every cycle against a behavioural reference model.
module tb_input_cmd_scheduler;

  localparam int unsigned DEB  = 16;
  localparam int unsigned DLY  = 32;
  localparam int unsigned RATE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_fall = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_fall = 1'b0;
  logic       finish = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [2:0] held;

  input_cmd_scheduler #(
    .DEB_CYCLES  (DEB),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_left (key_left),
    .key_right(key_right),
    .key_fall (key_fall),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_fall (btn_fall),
    .finish   (finish),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .held     (held)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model. Direction index: 0 left, 1 right, 2 fall (code = index+1).
  bit         m_rawq[3][$];   // raw button samples awaiting synchronisation
  bit         m_synq[3][$];   // last DEB synchronised samples
  bit         m_deb[3];
  bit         m_prev[3];      // effective level seen at the previous edge
  int         m_hold[3];      // cycles held since the press edge
  bit         m_pend[3];
  bit         m_issue;
  int         m_dir;
  int         m_rr;           // round-robin slot: 0 fall, 1 left, 2 right
  int         ord[3] = '{2, 0, 1};
  logic [1:0] acc_q[$];       // codes accepted by the consumer (DUT observed)

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] acc_at(input int i);
    if (acc_q.size() > i) return acc_q[i];
    return 2'bxx;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_rawq[d].delete();
      m_rawq[d].push_back(1'b0);
      m_rawq[d].push_back(1'b0);
      m_synq[d].delete();
      m_deb[d]  = 1'b0;
      m_prev[d] = 1'b0;
      m_hold[d] = 0;
      m_pend[d] = 1'b0;
    end
    m_issue = 1'b0;
    m_dir   = 0;
    m_rr    = 0;
  endtask

  task automatic model_edge();
    bit keys[3], btns[3], lvl[3], set[3];
    bit syn, agree, fnd;
    int dd;
    keys = '{key_left, key_right, key_fall};
    btns = '{btn_left, btn_right, btn_fall};
    for (int d = 0; d < 3; d++) lvl[d] = keys[d] | m_deb[d];
    if (lvl[0] && lvl[1]) begin
      lvl[0] = 1'b0;
      lvl[1] = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      set[d] = 1'b0;
      if (finish || !lvl[d]) m_hold[d] = 0;
      else if (!m_prev[d]) begin
        set[d]    = 1'b1;
        m_hold[d] = 0;
      end else begin
        m_hold[d]++;
        if (m_hold[d] >= DLY && ((m_hold[d] - DLY) % RATE) == 0) set[d] = 1'b1;
      end
    end
    if (!m_issue) begin
      fnd = 1'b0;
      if (!finish) begin
        for (int k = 0; k < 3; k++) begin
          dd = ord[(m_rr + k) % 3];
          if (!fnd && m_pend[dd]) begin
            fnd       = 1'b1;
            m_issue   = 1'b1;
            m_dir     = dd;
            m_pend[dd] = 1'b0;
          end
        end
      end
    end else if (cmd_ready) begin
      m_issue = 1'b0;
      for (int k = 0; k < 3; k++) if (ord[k] == m_dir) m_rr = (k + 1) % 3;
    end
    for (int d = 0; d < 3; d++) begin
      if (set[d]) m_pend[d] = 1'b1;
      if (finish) m_pend[d] = 1'b0;
      m_prev[d] = lvl[d];
    end
    for (int d = 0; d < 3; d++) begin
      syn = m_rawq[d].pop_front();
      m_rawq[d].push_back(btns[d]);
      m_synq[d].push_back(syn);
      if (m_synq[d].size() > DEB) void'(m_synq[d].pop_front());
      if (m_synq[d].size() == DEB) begin
        agree = 1'b1;
        foreach (m_synq[d][j]) if (m_synq[d][j] == m_deb[d]) agree = 1'b0;
        if (agree) m_deb[d] = ~m_deb[d];
      end
    end
  endtask

  task automatic check_model();
    chk("valid", 4'(cmd_valid), 4'(m_issue));
    chk("held", 4'(held), 4'({m_prev[2], m_prev[1], m_prev[0]}));
    if (m_issue) chk("code", 4'(cmd_code), 4'(m_dir + 1));
  endtask

  task automatic cyc();
    if (cmd_valid === 1'b1 && cmd_ready) acc_q.push_back(cmd_code);
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {key_left, key_right, key_fall} = '0;
    {btn_left, btn_right, btn_fall} = '0;
    finish    = 1'b0;
    cmd_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 4'(cmd_valid), 4'd0);
    chk("rst_code", 4'(cmd_code), 4'd0);
    chk("rst_held", 4'(held), 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    acc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nbad;

    // Keyboard single press: one command, valid two cycles after the rise.
    do_reset();
    cmd_ready = 1'b1;
    run(2);
    key_left = 1'b1;
    cyc(); chk("kb_lat0_v", 4'(cmd_valid), 4'd0);
    cyc(); chk("kb_lat1_v", 4'(cmd_valid), 4'd1); chk("kb_lat1_c", 4'(cmd_code), 4'd1);
    cyc(); chk("kb_lat2_v", 4'(cmd_valid), 4'd0);
    key_left = 1'b0;
    run(10);
    chk("kb_count", 4'(acc_q.size()), 4'd1);
    chk("kb_code", 4'(acc_at(0)), 4'd1);

    // Auto-repeat: 60-cycle hold gives press + 4 repeats.
    do_reset();
    cmd_ready = 1'b1;
    run(2);
    key_fall = 1'b1;
    run(60);
    key_fall = 1'b0;
    run(10);
    chk("rep_count", 4'(acc_q.size()), 4'd5);
    nbad = 0;
    foreach (acc_q[i]) if (acc_q[i] !== 2'b11) nbad++;
    chk("rep_codes", 4'(nbad), 4'd0);

    // Button debounce: bounce produces nothing, stable press one command.
    do_reset();
    cmd_ready = 1'b1;
    run(2);
    for (int s = 0; s < 8; s++) begin
      btn_right = (s % 2 == 0);
      run(5);
    end
    chk("bounce_none", 4'(acc_q.size()), 4'd0);
    btn_right = 1'b1;
    run(30);
    chk("deb_count", 4'(acc_q.size()), 4'd1);
    chk("deb_code", 4'(acc_at(0)), 4'd2);
    chk("deb_held", 4'(held), 4'b0010);

    // Conflict: left and right together are ignored.
    do_reset();
    cmd_ready = 1'b1;
    run(2);
    key_left  = 1'b1;
    key_right = 1'b1;
    run(10);
    chk("conf_held", 4'(held), 4'd0);
    chk("conf_count", 4'(acc_q.size()), 4'd0);
    key_left  = 1'b0;
    key_right = 1'b0;
    run(3);

    // Round-robin: fall, left, right all pending, granted in that order.
    do_reset();
    run(2);
    key_fall = 1'b1; cyc(); key_fall = 1'b0;
    key_left = 1'b1; cyc(); key_left = 1'b0;
    key_right = 1'b1; cyc(); key_right = 1'b0;
    run(3);
    cmd_ready = 1'b1;
    run(8);
    chk("rr_count", 4'(acc_q.size()), 4'd3);
    chk("rr_0", 4'(acc_at(0)), 4'd3);
    chk("rr_1", 4'(acc_at(1)), 4'd1);
    chk("rr_2", 4'(acc_at(2)), 4'd2);

    // Backpressure: command held stable for 20 cycles, accepted at once.
    do_reset();
    run(2);
    key_right = 1'b1; cyc(); key_right = 1'b0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("bp_valid", 4'(cmd_valid), 4'd1);
      chk("bp_code", 4'(cmd_code), 4'd2);
    end
    cmd_ready = 1'b1;
    cyc();
    chk("bp_drop", 4'(cmd_valid), 4'd0);
    chk("bp_count", 4'(acc_q.size()), 4'd1);

    // Finish: in-flight command completes, pending ones and new presses lost.
    do_reset();
    run(2);
    key_fall = 1'b1; cyc(); key_fall = 1'b0;
    key_left = 1'b1; cyc(); key_left = 1'b0;
    key_right = 1'b1; cyc(); key_right = 1'b0;
    run(2);
    finish    = 1'b1;
    cmd_ready = 1'b1;
    run(20);
    chk("fin_count", 4'(acc_q.size()), 4'd1);
    chk("fin_code", 4'(acc_at(0)), 4'd3);
    chk("fin_valid", 4'(cmd_valid), 4'd0);
    key_left = 1'b1; cyc(); key_left = 1'b0;
    run(3);
    finish = 1'b0;
    run(10);
    chk("fin_lost", 4'(acc_q.size()), 4'd1);

    // Reset mid-handshake: valid drops immediately, nothing replayed.
    do_reset();
    run(2);
    key_left = 1'b1; cyc(); key_left = 1'b0;
    cyc();
    chk("mid_valid", 4'(cmd_valid), 4'd1);
    #2 rst = 1'b0;
    #1 chk("mid_async", 4'(cmd_valid), 4'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    acc_q.delete();
    cmd_ready = 1'b1;
    run(15);
    chk("mid_noreplay", 4'(acc_q.size()), 4'd0);
    key_left = 1'b1;
    run(3);
    key_left = 1'b0;
    run(3);
    chk("mid_newpress", 4'(acc_q.size()), 4'd1);

    // Random phase against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) key_left  = ~key_left;
      if ($urandom_range(15) == 0) key_right = ~key_right;
      if ($urandom_range(15) == 0) key_fall  = ~key_fall;
      if ($urandom_range(39) == 0) btn_left  = ~btn_left;
      if ($urandom_range(39) == 0) btn_right = ~btn_right;
      if ($urandom_range(39) == 0) btn_fall  = ~btn_fall;
      if ($urandom_range(299) == 0) finish   = ~finish;
      cmd_ready = ($urandom_range(3) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
